// File: rtl/memory_wait.sv
// memory_wait: single-port synchronous RAM behind a req/ack handshake with a
//   programmable number of wait states, so a core can be run against slow memory.
// Latency: accept at cycle T -> ack pulse at T+1+latency; one access per latency+2 cycles.
// Backpressure: busy_o is high from T+1 through the ack cycle; req_i is ignored (not queued) while busy.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous reset, active high (RAM contents are not cleared)
//   req_i    access request, sampled only while busy_o=0
//   we_i     1 = write, 0 = read, sampled with req_i
//   addr_i   word address, sampled with req_i
//   wdata_i  write data, sampled with req_i
//   wstrb_i  byte-lane write enables (present only with MEM_WSTRB_EN)
//   rdata_o  read data, updated in the ack cycle of a read and held until the next read
//   ack_o    one-cycle completion pulse
//   busy_o   access in progress
//
// Build option: define MEM_WSTRB_EN to add wstrb_i; a write then updates only the
// enabled byte lanes (data_width must be a multiple of 8). Without it every write
// updates the full word.

module memory_wait #(
  parameter int data_width = 8,
  parameter int addr_width = 5,
  parameter int latency    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [addr_width-1:0]   addr_i,
  input  logic [data_width-1:0]   wdata_i,
`ifdef MEM_WSTRB_EN
  input  logic [data_width/8-1:0] wstrb_i,
`endif
  output logic [data_width-1:0]   rdata_o,
  output logic                    ack_o,
  output logic                    busy_o
);

  localparam int depth = 2 ** addr_width;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [addr_width-1:0]   addr_q;
  logic [data_width-1:0]   wdata_q;
  logic [data_width-1:0]   rdata_q;
  logic                    ack_q;
  logic                    busy_q;
`ifdef MEM_WSTRB_EN
  logic [data_width/8-1:0] wstrb_q;
  logic [data_width/8-1:0] acc_wstrb_d;
`endif

  logic [data_width-1:0]   mem_q [depth];

  // Access that commits on the coming edge (the edge that enters ACK).
  logic                    enter_ack_d;
  logic                    acc_we_d;
  logic [addr_width-1:0]   acc_addr_d;
  logic [data_width-1:0]   acc_wdata_d;
  logic                    wr_commit_d;

  always_comb begin
    enter_ack_d = 1'b0;
    if (state_q == IDLE) begin
      // Zero wait states: IDLE goes straight to ACK on acceptance.
      enter_ack_d = req_i && (latency == 0);
    end else if (state_q == WAIT) begin
      enter_ack_d = (cnt_q == 4'd1);
    end

    // From IDLE the commit can only be the zero-latency case, which has no
    // captured copy yet, so the live inputs are used; otherwise the captured ones.
    if (state_q == IDLE) begin
      acc_we_d    = we_i;
      acc_addr_d  = addr_i;
      acc_wdata_d = wdata_i;
`ifdef MEM_WSTRB_EN
      acc_wstrb_d = wstrb_i;
`endif
    end else begin
      acc_we_d    = we_q;
      acc_addr_d  = addr_q;
      acc_wdata_d = wdata_q;
`ifdef MEM_WSTRB_EN
      acc_wstrb_d = wstrb_q;
`endif
    end

    // Reset in the same cycle discards the pending write.
    wr_commit_d = enter_ack_d && acc_we_d && !rst_i;
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_WSTRB_EN
      wstrb_q <= '0;
`endif
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
`ifdef MEM_WSTRB_EN
            wstrb_q <= wstrb_i;
`endif
            cnt_q   <= 4'(latency);
            busy_q  <= 1'b1;
            if (latency == 0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (enter_ack_d && !acc_we_d) begin
        rdata_q <= mem_q[acc_addr_d];
      end
    end
  end

  // RAM array: no reset, written only on the edge entering ACK.
  always_ff @(posedge clk_i) begin
    if (wr_commit_d) begin
`ifdef MEM_WSTRB_EN
      for (int i = 0; i < data_width / 8; i++) begin
        if (acc_wstrb_d[i]) begin
          mem_q[acc_addr_d][8*i +: 8] <= acc_wdata_d[8*i +: 8];
        end
      end
`else
      mem_q[acc_addr_d] <= acc_wdata_d;
`endif
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;

endmodule
